vga_text_renderer: RTL and testbench

- Consumes the 800x600@72 timing generator's col/row/sync/blank outputs and produces a 1-bit text-mode pixel stream for the IMSAI 8080 terminal display.
- Displays 80x25 characters in 10x24 cells, using 8x12 glyphs with each glyph row drawn on two scanlines.
- Fetches character codes from an external synchronous text RAM and glyph rows from an external synchronous font ROM.
- Pipelines sync/blank to stay aligned with the pixel, and adds a blinking underline cursor.

---
 rtl/vga_text_renderer_if.sv | 9 +
 rtl/vga_text_renderer.sv | 93 +++++++++
 tb/tb_vga_text_renderer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_renderer_if.sv
// vga_text_renderer_if: text RAM and font ROM read ports of the text renderer
interface vga_text_renderer_if;
  logic [10:0] text_addr;
  logic [7:0] text_data;
  logic [10:0] font_addr;
  logic [7:0] font_data;
  modport master(output text_addr, font_addr, input text_data, font_data);
  modport slave(input text_addr, font_addr, output text_data, font_data);
endinterface

// File: rtl/vga_text_renderer.sv
// vga_text_renderer: 80x25 text-mode pixel generator with a blinking underline cursor
module vga_text_renderer #(
  parameter int H_START = 39,
  parameter int V_START = 23,
  parameter int COLS = 80,
  parameter int ROWS = 25,
  parameter int CELL_W = 10,
  parameter int CELL_H = 24,
  parameter int BLINK_BIT = 4
) (
  input logic clk50m,
  input logic reset_n,
  input logic [10:0] col,
  input logic [9:0] row,
  input logic hsync_i,
  input logic vsync_i,
  input logic hblank_i,
  input logic vblank_i,
  vga_text_renderer_if.master mem,
  input logic [6:0] cursor_col,
  input logic [4:0] cursor_row,
  input logic cursor_en,
  output logic pixel,
  output logic hsync_o,
  output logic vsync_o,
  output logic hblank_o,
  output logic vblank_o
);
  localparam int RW = (2048 + CELL_W - 1) / CELL_W;
  localparam int RH = (65536 + CELL_H - 1) / CELL_H;
  logic active, hit_d, blank_d, pixel_d, pixel_q, vs_q;
  logic [9:0] x, y;
  logic [6:0] cc;
  logic [4:0] cr, line;
  logic [3:0] px;
  logic [10:0] text_addr_d, text_addr_q, font_addr_d, font_addr_q;
  logic [7:0] frame_d, frame_q;
  logic [4:1][3:0] px_q;
  logic [4:1] hit_q, blank_q;
  logic [2:1][3:0] grow_q;
  logic [4:3] inv_q;
  logic [4:0][3:0] sync_q;
  // cell index via fixed-point reciprocal multiply, exact over the active range; remainders need only low bits
  always_comb begin
    x = 10'(col - 11'(H_START));
    y = row - 10'(V_START);
    active = col >= 11'(H_START) && col < 11'(H_START + COLS * CELL_W) &&
             row >= 10'(V_START) && row < 10'(V_START + ROWS * CELL_H);
    cc = 7'((18'(x) * 18'(RW)) >> 11);
    cr = 5'((21'(y) * 21'(RH)) >> 16);
    px = x[3:0] - cc[3:0] * 4'(CELL_W);
    line = y[4:0] - cr * 5'(CELL_H);
    text_addr_d = active ? 11'(cr) * 11'(COLS) + 11'(cc) : '0;
    blank_d = hblank_i | vblank_i | ~active;
    hit_d = cursor_en & frame_q[BLINK_BIT] & active & (cc == cursor_col) &
            (cr == cursor_row) & (line >= 5'(CELL_H - 2));
    font_addr_d = {mem.text_data[6:0], grow_q[2]};
    frame_d = frame_q + 8'(vs_q & ~vsync_i);
    pixel_d = blank_q[4] ? 1'b0 : hit_q[4] ? 1'b1 :
              (~px_q[4][3] & mem.font_data[~px_q[4][2:0]]) ^ inv_q[4];
  end
  always_ff @(posedge clk50m) begin
    if (!reset_n) begin
      text_addr_q <= '0;
      font_addr_q <= '0;
      pixel_q <= 1'b0;
      frame_q <= '0;
      vs_q <= 1'b1;
      px_q <= '0;
      hit_q <= '0;
      blank_q <= '1;
      grow_q <= '0;
      inv_q <= '0;
      sync_q <= '1;
    end else begin
      text_addr_q <= text_addr_d;
      font_addr_q <= font_addr_d;
      pixel_q <= pixel_d;
      frame_q <= frame_d;
      vs_q <= vsync_i;
      px_q <= {px_q[3:1], px};
      hit_q <= {hit_q[3:1], hit_d};
      blank_q <= {blank_q[3:1], blank_d};
      grow_q <= {grow_q[1], line[4:1]};
      inv_q <= {inv_q[3], mem.text_data[7]};
      sync_q <= {sync_q[3:0], {hsync_i, vsync_i, hblank_i, vblank_i}};
    end
  end
  assign mem.text_addr = text_addr_q;
  assign mem.font_addr = font_addr_q;
  assign pixel = pixel_q;
  assign {hsync_o, vsync_o, hblank_o, vblank_o} = sync_q[4];
endmodule

// File: tb/tb_vga_text_renderer.sv
// tb_vga_text_renderer: directed checks of the text renderer against hand-computed pixels
`timescale 1ns/1ps
module tb_vga_text_renderer;
  logic clk50m = 1'b0;
  logic reset_n;
  logic [10:0] col;
  logic [9:0] row;
  logic hsync_i, vsync_i, hblank_i, vblank_i;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic cursor_en;
  logic pixel, hsync_o, vsync_o, hblank_o, vblank_o;
  logic [7:0] ram [2048];
  logic [7:0] rom [2048];
  logic [10:0] ta [16];
  logic [10:0] fa [16];
  logic pix [16];
  int checks = 0;
  int errors = 0;
  vga_text_renderer_if bus();
  vga_text_renderer dut (
    .clk50m(clk50m), .reset_n(reset_n), .col(col), .row(row),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .hblank_i(hblank_i), .vblank_i(vblank_i),
    .mem(bus), .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
    .pixel(pixel), .hsync_o(hsync_o), .vsync_o(vsync_o), .hblank_o(hblank_o), .vblank_o(vblank_o)
  );
  always #10 clk50m = ~clk50m;
  always @(posedge clk50m) begin
    bus.text_data <= ram[bus.text_addr];
    bus.font_data <= rom[bus.font_addr];
  end
  task automatic step();
    @(posedge clk50m);
    #1;
  endtask
  task automatic pulse_vsync(input int n);
    repeat (n) begin
      vsync_i = 1'b0;
      step();
      vsync_i = 1'b1;
      step();
    end
  endtask
  // drive n consecutive columns, capturing each column's text_addr, font_addr and pixel at their stage
  task automatic run_line(input int c0, input int r, input int n, input logic hb);
    col = 11'(c0);
    row = 10'(r);
    hblank_i = hb;
    vblank_i = 1'b0;
    for (int s = 1; s <= n + 5; s++) begin
      step();
      if (s <= n) ta[s-1] = bus.text_addr;
      if (s >= 3 && s - 3 < n) fa[s-3] = bus.font_addr;
      if (s >= 5) pix[s-5] = pixel;
      if (s < n) col = 11'(c0 + s);
      else hblank_i = 1'b1;
    end
  endtask
  task automatic test_reset();
    reset_n = 1'b0; col = 11'd89; row = 10'd117;
    hsync_i = 1'b0; vsync_i = 1'b1; hblank_i = 1'b0; vblank_i = 1'b0;
    cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    step(); step();
    checks++; if (pixel !== 1'b0) begin errors++; $display("FAIL reset_pixel got %b want 0", pixel); end
    checks++; if (hsync_o !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", hsync_o); end
    checks++; if (vsync_o !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vsync_o); end
    checks++; if (hblank_o !== 1'b1) begin errors++; $display("FAIL reset_hblank got %b want 1", hblank_o); end
    checks++; if (vblank_o !== 1'b1) begin errors++; $display("FAIL reset_vblank got %b want 1", vblank_o); end
    checks++; if (bus.text_addr !== 11'd0) begin errors++; $display("FAIL reset_text_addr got %0d want 0", bus.text_addr); end
    checks++; if (bus.font_addr !== 11'd0) begin errors++; $display("FAIL reset_font_addr got %h want 0", bus.font_addr); end
    reset_n = 1'b1;
    repeat (6) step();
    checks++; if (bus.text_addr !== 11'd245) begin errors++; $display("FAIL run_text_addr got %0d want 245", bus.text_addr); end
    checks++; if (hsync_o !== 1'b0) begin errors++; $display("FAIL run_hsync got %b want 0", hsync_o); end
    checks++; if (hblank_o !== 1'b0) begin errors++; $display("FAIL run_hblank got %b want 0", hblank_o); end
    reset_n = 1'b0;
    step(); step();
    checks++; if (bus.text_addr !== 11'd0) begin errors++; $display("FAIL midreset_text_addr got %0d want 0", bus.text_addr); end
    checks++; if (hsync_o !== 1'b1) begin errors++; $display("FAIL midreset_hsync got %b want 1", hsync_o); end
    checks++; if (hblank_o !== 1'b1) begin errors++; $display("FAIL midreset_hblank got %b want 1", hblank_o); end
    checks++; if (pixel !== 1'b0) begin errors++; $display("FAIL midreset_pixel got %b want 0", pixel); end
    hsync_i = 1'b1;
  endtask
  task automatic test_latency();
    ram[0] = 8'h41;
    rom[11'h410] = 8'h80;
    reset_n = 1'b1;
    run_line(39, 23, 8, 1'b0);
    checks++; if (ta[0] !== 11'd0) begin errors++; $display("FAIL lat_text_addr got %0d want 0", ta[0]); end
    checks++; if (fa[0] !== 11'h410) begin errors++; $display("FAIL lat_font_addr got %h want 410", fa[0]); end
    checks++; if (pix[0] !== 1'b1) begin errors++; $display("FAIL lat_pixel0 got %b want 1", pix[0]); end
    for (int k = 1; k < 8; k++) begin
      checks++; if (pix[k] !== 1'b0) begin errors++; $display("FAIL lat_pixel%0d got %b want 0", k, pix[k]); end
    end
  endtask
  task automatic test_corner();
    ram[1999] = 8'h5A;
    rom[11'h5AB] = 8'hFF;
    run_line(836, 622, 3, 1'b0);
    checks++; if (ta[2] !== 11'd1999) begin errors++; $display("FAIL corner_text_addr got %0d want 1999", ta[2]); end
    checks++; if (fa[2] !== 11'h5AB) begin errors++; $display("FAIL corner_font_addr got %h want 5ab", fa[2]); end
    checks++; if (pix[0] !== 1'b1) begin errors++; $display("FAIL corner_px7 got %b want 1", pix[0]); end
    checks++; if (pix[1] !== 1'b0) begin errors++; $display("FAIL corner_px8 got %b want 0", pix[1]); end
    checks++; if (pix[2] !== 1'b0) begin errors++; $display("FAIL corner_px9 got %b want 0", pix[2]); end
  endtask
  task automatic test_inverse();
    logic [9:0] e;
    e = 10'b1111000011;
    ram[2] = 8'hC1;
    rom[11'h411] = 8'h0F;
    run_line(59, 25, 10, 1'b0);
    checks++; if (fa[0] !== 11'h411) begin errors++; $display("FAIL inv_font_addr got %h want 411", fa[0]); end
    for (int k = 0; k < 10; k++) begin
      checks++; if (pix[k] !== e[9-k]) begin errors++; $display("FAIL inv_px%0d got %b want %b", k, pix[k], e[9-k]); end
    end
  endtask
  task automatic test_cursor();
    ram[245] = 8'h20;
    cursor_col = 7'd5; cursor_row = 5'd3; cursor_en = 1'b1;
    pulse_vsync(16);
    run_line(88, 117, 11, 1'b0);
    checks++; if (ta[1] !== 11'd245) begin errors++; $display("FAIL cur_text_addr got %0d want 245", ta[1]); end
    checks++; if (pix[0] !== 1'b0) begin errors++; $display("FAIL cur_left_cell got %b want 0", pix[0]); end
    for (int k = 1; k <= 10; k++) begin
      checks++; if (pix[k] !== 1'b1) begin errors++; $display("FAIL cur_l22_px%0d got %b want 1", k - 1, pix[k]); end
    end
    run_line(89, 118, 10, 1'b0);
    for (int k = 0; k < 10; k++) begin
      checks++; if (pix[k] !== 1'b1) begin errors++; $display("FAIL cur_l23_px%0d got %b want 1", k, pix[k]); end
    end
    run_line(89, 116, 10, 1'b0);
    for (int k = 0; k < 10; k++) begin
      checks++; if (pix[k] !== 1'b0) begin errors++; $display("FAIL cur_l21_px%0d got %b want 0", k, pix[k]); end
    end
    pulse_vsync(16);
    run_line(89, 117, 10, 1'b0);
    for (int k = 0; k < 10; k++) begin
      checks++; if (pix[k] !== 1'b0) begin errors++; $display("FAIL cur_off_px%0d got %b want 0", k, pix[k]); end
    end
    cursor_en = 1'b0;
    pulse_vsync(16);
    run_line(89, 117, 10, 1'b0);
    for (int k = 0; k < 10; k++) begin
      checks++; if (pix[k] !== 1'b0) begin errors++; $display("FAIL cur_dis_px%0d got %b want 0", k, pix[k]); end
    end
  endtask
  task automatic test_blank();
    for (int i = 0; i < 2048; i++) rom[i] = 8'hFF;
    run_line(38, 23, 1, 1'b0);
    checks++; if (pix[0] !== 1'b0) begin errors++; $display("FAIL blank_col38 got %b want 0", pix[0]); end
    run_line(839, 23, 1, 1'b0);
    checks++; if (pix[0] !== 1'b0) begin errors++; $display("FAIL blank_col839 got %b want 0", pix[0]); end
    run_line(39, 23, 1, 1'b1);
    checks++; if (pix[0] !== 1'b0) begin errors++; $display("FAIL blank_hblank got %b want 0", pix[0]); end
    run_line(40, 23, 1, 1'b0);
    checks++; if (pix[0] !== 1'b1) begin errors++; $display("FAIL blank_lit got %b want 1", pix[0]); end
  endtask
  task automatic test_sync();
    hsync_i = 1'b1; vsync_i = 1'b1; hblank_i = 1'b0; vblank_i = 1'b0;
    repeat (6) step();
    hsync_i = 1'b0; hblank_i = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      step();
      if (s == 4) begin
        checks++; if (hsync_o !== 1'b1) begin errors++; $display("FAIL sync_hs_t4 got %b want 1", hsync_o); end
        checks++; if (hblank_o !== 1'b0) begin errors++; $display("FAIL sync_hb_t4 got %b want 0", hblank_o); end
      end
      if (s == 5) begin
        checks++; if (hsync_o !== 1'b0) begin errors++; $display("FAIL sync_hs_t5 got %b want 0", hsync_o); end
        checks++; if (hblank_o !== 1'b1) begin errors++; $display("FAIL sync_hb_t5 got %b want 1", hblank_o); end
        checks++; if (vsync_o !== 1'b1) begin errors++; $display("FAIL sync_vs_t5 got %b want 1", vsync_o); end
        checks++; if (vblank_o !== 1'b0) begin errors++; $display("FAIL sync_vb_t5 got %b want 0", vblank_o); end
      end
      if (s == 6) begin
        checks++; if (vsync_o !== 1'b0) begin errors++; $display("FAIL sync_vs_t6 got %b want 0", vsync_o); end
        checks++; if (vblank_o !== 1'b1) begin errors++; $display("FAIL sync_vb_t6 got %b want 1", vblank_o); end
      end
      if (s == 1) begin
        vsync_i = 1'b0;
        vblank_i = 1'b1;
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i] = 8'h00;
      rom[i] = 8'h00;
    end
    test_reset();
    test_latency();
    test_corner();
    test_inverse();
    test_cursor();
    test_blank();
    test_sync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
